// File: rtl/issue_ctrl_pkg.sv
// issue_ctrl_pkg: shared constants for the dual-issue dispatch controller.
//   DECODE_DATA_WIDTH : width of one decoded instruction payload
//   ISS_CLASS_*       : 3-bit instruction class codes from the decoder
//   iss_state_e       : dispatch FSM state encoding
package issue_ctrl_pkg;

    localparam int DECODE_DATA_WIDTH = 32;

    localparam logic [2:0] ISS_CLASS_ALU    = 3'd0;
    localparam logic [2:0] ISS_CLASS_BRANCH = 3'd1;
    localparam logic [2:0] ISS_CLASS_MEM    = 3'd2;
    localparam logic [2:0] ISS_CLASS_MULDIV = 3'd3;
    localparam logic [2:0] ISS_CLASS_SERIAL = 3'd4;

    typedef enum logic [1:0] {
        ISS_ST_NORMAL    = 2'd0,
        ISS_ST_SER_WAIT  = 2'd1,
        ISS_ST_SER_DRAIN = 2'd2
    } iss_state_e;

endpackage

// File: rtl/issue_pair_check.sv
// issue_pair_check: decides whether head+1 may be co-issued with the head.
//   cls0_i, cls1_i : classes of head / head+1
//   rd0_i, wen0_i  : destination register and write enable of head
//   rj1_i, rk1_i   : source registers of head+1
//   ren1_i         : source read enables of head+1 ({rk, rj})
//   pair_ok_o      : 1 when both entries can leave in the same cycle
module issue_pair_check
    import issue_ctrl_pkg::*;
(
    input  logic [2:0] cls0_i,
    input  logic [2:0] cls1_i,
    input  logic [4:0] rd0_i,
    input  logic       wen0_i,
    input  logic [4:0] rj1_i,
    input  logic [4:0] rk1_i,
    input  logic [1:0] ren1_i,
    output logic       pair_ok_o
);

    logic any_serial;
    logic mem_conflict;
    logic muldiv_conflict;
    logic raw_hazard;

    always_comb begin
        any_serial      = (cls0_i == ISS_CLASS_SERIAL) || (cls1_i == ISS_CLASS_SERIAL);
        // Only one LSU and one multiplier/divider in the backend.
        mem_conflict    = (cls0_i == ISS_CLASS_MEM) && (cls1_i == ISS_CLASS_MEM);
        muldiv_conflict = (cls0_i == ISS_CLASS_MULDIV) && (cls1_i == ISS_CLASS_MULDIV);
        // r0 is hardwired to zero, so a write to it never creates a dependency.
        raw_hazard      = wen0_i && (rd0_i != 5'd0) &&
                          ((ren1_i[0] && (rj1_i == rd0_i)) ||
                           (ren1_i[1] && (rk1_i == rd0_i)));
        pair_ok_o       = !(any_serial || mem_conflict || muldiv_conflict || raw_hazard);
    end

endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue dispatch between the decode FIFO and the issue stage.
// Pops 0, 1 or 2 head entries per cycle into a registered slot pair; serializing
// instructions go out alone on a drained backend.
//
//   state            | meaning
//   ISS_ST_NORMAL    | normal single/dual dispatch
//   ISS_ST_SER_WAIT  | serializing op at head, waiting for empty slots + idle backend
//   ISS_ST_SER_DRAIN | serializing op issued, waiting for it to retire
//
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   flush_i                      : pipeline flush, clears slot valids
//   fifo_valid_i                 : head / head+1 occupancy
//   fifo_data0_i, fifo_data1_i   : head / head+1 payloads
//   cls0_i, cls1_i               : head / head+1 classes
//   rd0_i, wen0_i                : head destination + write enable
//   rj1_i, rk1_i, ren1_i         : head+1 sources + read enables
//   deq_en_o                     : combinational pop request (00/01/11)
//   issue_valid_o                : registered slot valids
//   issue_data0_o, issue_data1_o : registered slot payloads
//   issue_ready_i                : backend accepts the slot pair
//   backend_idle_i               : nothing in flight beyond the issue register
//   serial_busy_o                : FSM is outside NORMAL
module issue_ctrl
    import issue_ctrl_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [1:0]                   fifo_valid_i,
    input  logic [DECODE_DATA_WIDTH-1:0] fifo_data0_i,
    input  logic [DECODE_DATA_WIDTH-1:0] fifo_data1_i,
    input  logic [2:0]                   cls0_i,
    input  logic [2:0]                   cls1_i,
    input  logic [4:0]                   rd0_i,
    input  logic                         wen0_i,
    input  logic [4:0]                   rj1_i,
    input  logic [4:0]                   rk1_i,
    input  logic [1:0]                   ren1_i,
    output logic [1:0]                   deq_en_o,
    output logic [1:0]                   issue_valid_o,
    output logic [DECODE_DATA_WIDTH-1:0] issue_data0_o,
    output logic [DECODE_DATA_WIDTH-1:0] issue_data1_o,
    input  logic                         issue_ready_i,
    input  logic                         backend_idle_i,
    output logic                         serial_busy_o
);

    iss_state_e                   state_q, state_d;
    logic [1:0]                   valid_q, valid_d;
    logic [DECODE_DATA_WIDTH-1:0] data0_q, data0_d;
    logic [DECODE_DATA_WIDTH-1:0] data1_q, data1_d;
    logic                         pair_ok;
    logic                         load;
    logic                         slots_empty;

    issue_pair_check u_pair_check (
        .cls0_i    (cls0_i),
        .cls1_i    (cls1_i),
        .rd0_i     (rd0_i),
        .wen0_i    (wen0_i),
        .rj1_i     (rj1_i),
        .rk1_i     (rk1_i),
        .ren1_i    (ren1_i),
        .pair_ok_o (pair_ok)
    );

    assign slots_empty = !(|valid_q);
    assign load        = slots_empty || issue_ready_i;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        deq_en_o = 2'b00;

        if (rst_i) begin
            // Registers are cleared by the sequential block; only keep the pop quiet.
            deq_en_o = 2'b00;
        end else if (flush_i) begin
            valid_d = 2'b00;
            state_d = ISS_ST_NORMAL;
        end else begin
            unique case (state_q)
                ISS_ST_NORMAL: begin
                    if (cls0_i == ISS_CLASS_SERIAL && fifo_valid_i[0]) begin
                        state_d = ISS_ST_SER_WAIT;
                        if (load) valid_d = 2'b00;
                    end else if (load) begin
                        if (!fifo_valid_i[0]) begin
                            valid_d = 2'b00;
                        end else if (fifo_valid_i[1] && pair_ok) begin
                            deq_en_o = 2'b11;
                            valid_d  = 2'b11;
                            data0_d  = fifo_data0_i;
                            data1_d  = fifo_data1_i;
                        end else begin
                            deq_en_o = 2'b01;
                            valid_d  = 2'b01;
                            data0_d  = fifo_data0_i;
                        end
                    end
                end
                ISS_ST_SER_WAIT: begin
                    if (backend_idle_i && slots_empty && fifo_valid_i[0]) begin
                        deq_en_o = 2'b01;
                        valid_d  = 2'b01;
                        data0_d  = fifo_data0_i;
                        state_d  = ISS_ST_SER_DRAIN;
                    end else if (load) begin
                        valid_d = 2'b00;
                    end
                end
                ISS_ST_SER_DRAIN: begin
                    if (load) valid_d = 2'b00;
                    if (slots_empty && backend_idle_i) state_d = ISS_ST_NORMAL;
                end
                default: begin
                    state_d = ISS_ST_NORMAL;
                    valid_d = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ISS_ST_NORMAL;
            valid_q <= 2'b00;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    assign issue_valid_o = valid_q;
    assign issue_data0_o = data0_q;
    assign issue_data1_o = data1_q;
    assign serial_busy_o = (state_q != ISS_ST_NORMAL);

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;
    import issue_ctrl_pkg::*;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    logic [1:0]                   fifo_valid;
    logic [DECODE_DATA_WIDTH-1:0] fifo_data0;
    logic [DECODE_DATA_WIDTH-1:0] fifo_data1;
    logic [2:0]                   cls0;
    logic [2:0]                   cls1;
    logic [4:0]                   rd0;
    logic                         wen0;
    logic [4:0]                   rj1;
    logic [4:0]                   rk1;
    logic [1:0]                   ren1;
    logic [1:0]                   deq_en;
    logic [1:0]                   issue_valid;
    logic [DECODE_DATA_WIDTH-1:0] issue_data0;
    logic [DECODE_DATA_WIDTH-1:0] issue_data1;
    logic                         issue_ready;
    logic                         backend_idle;
    logic                         serial_busy;

    int checks   = 0;
    int failures = 0;

    issue_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .fifo_valid_i   (fifo_valid),
        .fifo_data0_i   (fifo_data0),
        .fifo_data1_i   (fifo_data1),
        .cls0_i         (cls0),
        .cls1_i         (cls1),
        .rd0_i          (rd0),
        .wen0_i         (wen0),
        .rj1_i          (rj1),
        .rk1_i          (rk1),
        .ren1_i         (ren1),
        .deq_en_o       (deq_en),
        .issue_valid_o  (issue_valid),
        .issue_data0_o  (issue_data0),
        .issue_data1_o  (issue_data1),
        .issue_ready_i  (issue_ready),
        .backend_idle_i (backend_idle),
        .serial_busy_o  (serial_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic head(input logic [1:0] fv, input logic [2:0] c0, input logic [2:0] c1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] r0, input logic w0,
                        input logic [4:0] j1, input logic [4:0] k1, input logic [1:0] e1);
        fifo_valid = fv; cls0 = c0; cls1 = c1; fifo_data0 = d0; fifo_data1 = d1;
        rd0 = r0; wen0 = w0; rj1 = j1; rk1 = k1; ren1 = e1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b1; backend_idle = 1'b1;
        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_ALU, 32'h1111, 32'h2222, 5'd1, 1'b1, 5'd2, 5'd3, 2'b11);
        tick(); tick();
        settle();
        chk("rst_deq", deq_en, 2'b00);
        chk("rst_valid", issue_valid, 2'b00);
        chk("rst_data0", issue_data0, 0);
        chk("rst_data1", issue_data1, 0);
        chk("rst_busy", serial_busy, 1'b0);
        tick();
        rst = 1'b0;

        // ALU + ALU, independent sources
        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_ALU, 32'hA001, 32'hA002, 5'd5, 1'b1, 5'd6, 5'd7, 2'b11);
        settle(); chk("alu_pair_deq", deq_en, 2'b11);
        tick();
        chk("alu_pair_valid", issue_valid, 2'b11);
        chk("alu_pair_d0", issue_data0, 32'hA001);
        chk("alu_pair_d1", issue_data1, 32'hA002);

        // RAW on rj
        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_ALU, 32'hB001, 32'hB002, 5'd5, 1'b1, 5'd5, 5'd9, 2'b01);
        settle(); chk("raw_deq", deq_en, 2'b01);
        tick();
        chk("raw_valid", issue_valid, 2'b01);
        chk("raw_d0", issue_data0, 32'hB001);
        head(2'b01, ISS_CLASS_ALU, ISS_CLASS_ALU, 32'hB002, 32'h0, 5'd8, 1'b1, 5'd0, 5'd0, 2'b00);
        settle(); chk("raw_next_deq", deq_en, 2'b01);
        tick();
        chk("raw_next_d0", issue_data0, 32'hB002);

        // RAW on rk only
        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_BRANCH, 32'hB101, 32'hB102, 5'd12, 1'b1, 5'd3, 5'd12, 2'b10);
        settle(); chk("raw_rk_deq", deq_en, 2'b01);
        tick();

        head(2'b11, ISS_CLASS_MEM, ISS_CLASS_MEM, 32'hC001, 32'hC002, 5'd3, 1'b0, 5'd4, 5'd4, 2'b11);
        settle(); chk("mem_mem_deq", deq_en, 2'b01);
        tick(); chk("mem_mem_valid", issue_valid, 2'b01);

        head(2'b11, ISS_CLASS_MULDIV, ISS_CLASS_MULDIV, 32'hC101, 32'hC102, 5'd3, 1'b0, 5'd4, 5'd4, 2'b11);
        settle(); chk("muldiv_deq", deq_en, 2'b01);
        tick();

        head(2'b11, ISS_CLASS_MEM, ISS_CLASS_MULDIV, 32'hC201, 32'hC202, 5'd0, 1'b1, 5'd0, 5'd0, 2'b11);
        settle(); chk("r0_pair_deq", deq_en, 2'b11);
        tick();
        chk("r0_pair_valid", issue_valid, 2'b11);
        chk("r0_pair_d1", issue_data1, 32'hC202);

        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_SERIAL, 32'hC301, 32'hC302, 5'd1, 1'b0, 5'd0, 5'd0, 2'b00);
        settle(); chk("slot1_serial_deq", deq_en, 2'b01);
        tick();

        // Serializing op at head with busy backend
        backend_idle = 1'b0;
        head(2'b01, ISS_CLASS_SERIAL, ISS_CLASS_ALU, 32'hD001, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);
        settle(); chk("ser_enter_deq", deq_en, 2'b00);
        tick();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ser_wait_deq", deq_en, 2'b00);
            chk("ser_wait_busy", serial_busy, 1'b1);
            tick();
        end
        backend_idle = 1'b1;
        settle(); chk("ser_issue_deq", deq_en, 2'b01);
        tick();
        chk("ser_issue_valid", issue_valid, 2'b01);
        chk("ser_issue_d0", issue_data0, 32'hD001);
        chk("ser_drain_busy", serial_busy, 1'b1);
        issue_ready = 1'b0; backend_idle = 1'b0;
        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_ALU, 32'hD101, 32'hD102, 5'd1, 1'b0, 5'd2, 5'd3, 2'b11);
        settle(); chk("drain_hold_deq", deq_en, 2'b00);
        tick();
        chk("drain_hold_valid", issue_valid, 2'b01);
        issue_ready = 1'b1; backend_idle = 1'b1;
        settle(); chk("drain_accept_deq", deq_en, 2'b00);
        tick();
        chk("drain_accept_valid", issue_valid, 2'b00);
        chk("drain_still_busy", serial_busy, 1'b1);
        settle(); chk("drain_last_deq", deq_en, 2'b00);
        tick();
        chk("back_normal_busy", serial_busy, 1'b0);
        settle(); chk("after_ser_deq", deq_en, 2'b11);
        tick();
        chk("after_ser_valid", issue_valid, 2'b11);

        // Backpressure then flush
        issue_ready = 1'b0;
        head(2'b11, ISS_CLASS_ALU, ISS_CLASS_ALU, 32'hE001, 32'hE002, 5'd1, 1'b0, 5'd2, 5'd3, 2'b11);
        settle(); chk("bp_deq0", deq_en, 2'b00);
        tick();
        chk("bp_valid0", issue_valid, 2'b11);
        chk("bp_d0", issue_data0, 32'hD101);
        chk("bp_d1", issue_data1, 32'hD102);
        flush = 1'b1;
        settle(); chk("flush_deq", deq_en, 2'b00);
        tick();
        flush = 1'b0;
        chk("flush_valid", issue_valid, 2'b00);
        chk("flush_busy", serial_busy, 1'b0);
        settle(); chk("post_flush_deq", deq_en, 2'b11);
        tick();
        chk("post_flush_d0", issue_data0, 32'hE001);

        // Reset in the middle of SER_WAIT
        issue_ready = 1'b1; backend_idle = 1'b0;
        head(2'b01, ISS_CLASS_SERIAL, ISS_CLASS_ALU, 32'hF001, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00);
        tick();
        settle(); chk("rst_mid_busy_pre", serial_busy, 1'b1);
        rst = 1'b1;
        settle(); chk("rst_mid_deq", deq_en, 2'b00);
        tick();
        chk("rst_mid_valid", issue_valid, 2'b00);
        chk("rst_mid_busy", serial_busy, 1'b0);
        chk("rst_mid_d0", issue_data0, 0);
        settle(); chk("rst_mid_deq_hold", deq_en, 2'b00);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
